// File: rtl/fp_unit_arbiter.sv
// Round-robin issue stage sharing one fixed-latency pipelined FP unit between NUM_REQ requesters.
// Optional power-save clock gating of the unit and tag pipeline: define FP_ARB_POWER_SAVE_EN.
module fp_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 7,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] dataa,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         unit_dataa,
    output logic                      unit_clk_en,
    input  logic [DATA_W-1:0]         unit_result,
    output logic [DATA_W-1:0]         result,
    output logic [NUM_REQ-1:0]        done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]            grant_q, grant_d;
    logic [DATA_W-1:0]             unit_dataa_q, unit_dataa_d;
    logic                          issue_vld_q, issue_vld_d;
    logic [IDX_W-1:0]              issue_tag_q, issue_tag_d;
    logic [IDX_W-1:0]              last_q, last_d;
    logic [LATENCY-1:0]            stg_vld_q, stg_vld_d;
    logic [LATENCY-1:0][IDX_W-1:0] stg_tag_q, stg_tag_d;
    logic [DATA_W-1:0]             result_q, result_d;
    logic [NUM_REQ-1:0]            done_q, done_d;

    logic [NUM_REQ-1:0] cand;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        scan;
    logic               clk_en;

`ifdef FP_ARB_POWER_SAVE_EN
    assign clk_en = issue_vld_q | (|stg_vld_q);
`else
    assign clk_en = 1'b1;
`endif

    // Round-robin pick starting after the last granted index; a requester granted this cycle sits out.
    always_comb begin
        cand     = req & ~grant_q;
        pick_vld = 1'b0;
        pick_idx = last_q;
        scan     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan = (32'(last_q) + k) % NUM_REQ;
            if (!pick_vld && cand[scan[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_d      = '0;
        unit_dataa_d = unit_dataa_q;
        issue_vld_d  = pick_vld;
        issue_tag_d  = pick_idx;
        last_d       = last_q;
        stg_vld_d    = stg_vld_q;
        stg_tag_d    = stg_tag_q;
        result_d     = result_q;
        done_d       = '0;

        if (pick_vld) begin
            grant_d[pick_idx] = 1'b1;
            unit_dataa_d      = dataa[32'(pick_idx) * DATA_W +: DATA_W];
            last_d            = pick_idx;
        end

        // Tag pipeline mirrors the unit's pipeline and only moves when the unit is enabled.
        if (clk_en) begin
            for (int s = int'(LATENCY) - 1; s >= 1; s--) begin
                stg_vld_d[s] = stg_vld_q[s-1];
                stg_tag_d[s] = stg_tag_q[s-1];
            end
            stg_vld_d[0] = issue_vld_q;
            stg_tag_d[0] = issue_tag_q;

            if (stg_vld_q[LATENCY-1]) begin
                done_d[stg_tag_q[LATENCY-1]] = 1'b1;
                result_d                     = unit_result;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q      <= '0;
            unit_dataa_q <= '0;
            issue_vld_q  <= 1'b0;
            issue_tag_q  <= '0;
            last_q       <= LAST_RST;
            stg_vld_q    <= '0;
            stg_tag_q    <= '0;
            result_q     <= '0;
            done_q       <= '0;
        end else begin
            grant_q      <= grant_d;
            unit_dataa_q <= unit_dataa_d;
            issue_vld_q  <= issue_vld_d;
            issue_tag_q  <= issue_tag_d;
            last_q       <= last_d;
            stg_vld_q    <= stg_vld_d;
            stg_tag_q    <= stg_tag_d;
            result_q     <= result_d;
            done_q       <= done_d;
        end
    end

    assign grant       = grant_q;
    assign unit_dataa  = unit_dataa_q;
    assign unit_clk_en = clk_en;
    assign result      = result_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a behavioural int-to-float unit model of fixed latency.
module tb_fp_unit_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LATENCY = 7;
    localparam int unsigned DATA_W  = 32;

`ifdef FP_ARB_POWER_SAVE_EN
    localparam bit PS = 1'b1;
`else
    localparam bit PS = 1'b0;
`endif

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] dataa;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         unit_dataa;
    logic                      unit_clk_en;
    logic [DATA_W-1:0]         unit_result;
    logic [DATA_W-1:0]         result;
    logic [NUM_REQ-1:0]        done;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] unit_pipe [LATENCY];
    logic [31:0]       fconst [4];

    fp_unit_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .dataa       (dataa),
        .grant       (grant),
        .unit_dataa  (unit_dataa),
        .unit_clk_en (unit_clk_en),
        .unit_result (unit_result),
        .result      (result),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Unsigned int to float32, exact for operands below 2^24.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        int p;
        logic [31:0] m;
        if (x == 0) return 32'h0;
        p = 31;
        while (p > 0 && !x[p]) p--;
        m = (x << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Shared unit model: samples unit_dataa on enabled edges, result valid LATENCY enabled cycles later.
    always @(posedge clock) begin
        if (unit_clk_en) begin
            unit_pipe[0] <= i2f(unit_dataa);
            for (int s = 1; s < int'(LATENCY); s++) unit_pipe[s] <= unit_pipe[s-1];
        end
    end
    assign unit_result = unit_pipe[LATENCY-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        fconst[0] = 32'h3F80_0000;
        fconst[1] = 32'h4000_0000;
        fconst[2] = 32'h4040_0000;
        fconst[3] = 32'h4080_0000;
        for (int s = 0; s < int'(LATENCY); s++) unit_pipe[s] = '0;
        reset = 1'b1;
        req   = '0;
        dataa = '0;
        repeat (2) tick();
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_unit_dataa", unit_dataa, 32'h0);
        reset = 1'b0;

        // Single op from requester 2.
        dataa[2*DATA_W +: DATA_W] = 32'd100;
        req = 4'b0100;
        tick();
        check_eq("t1_grant", 32'(grant), 32'h4);
        check_eq("t1_unit_dataa", unit_dataa, 32'd100);
        req = '0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            check_eq($sformatf("t1_done_c%0d", c), 32'(done), (c == 9) ? 32'h4 : 32'h0);
            if (c == 2) check_eq("t1_grant_off", 32'(grant), 32'h0);
            if (c == 9) check_eq("t1_result", result, 32'h42C8_0000);
        end

        // All four request for eight grant edges.
        pulse_reset();
        for (int i = 0; i < 4; i++) dataa[i*DATA_W +: DATA_W] = 32'(i + 1);
        req = 4'b1111;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 8) req = '0;
            check_eq($sformatf("t2_grant_c%0d", k), 32'(grant),
                     (k <= 8) ? (32'h1 << ((k - 1) % 4)) : 32'h0);
            if (k <= 8)
                check_eq($sformatf("t2_udata_c%0d", k), unit_dataa, 32'(((k - 1) % 4) + 1));
            check_eq($sformatf("t2_done_c%0d", k), 32'(done),
                     (k >= 9 && k <= 16) ? (32'h1 << ((k - 9) % 4)) : 32'h0);
            if (k >= 9 && k <= 16)
                check_eq($sformatf("t2_result_c%0d", k), result, fconst[(k - 9) % 4]);
        end

        // Requesters 1 and 3 held high starting with last = 1.
        pulse_reset();
        req = 4'b0010;
        tick();
        check_eq("t3_first", 32'(grant), 32'h2);
        req = 4'b1010;
        for (int k = 2; k <= 9; k++) begin
            tick();
            check_eq($sformatf("t3_grant_c%0d", k), 32'(grant), (k % 2 == 0) ? 32'h8 : 32'h2);
        end
        req = '0;
        repeat (12) tick();

        // Reset flushes two in-flight ops.
        pulse_reset();
        req = 4'b0011;
        tick();
        check_eq("t4_g0", 32'(grant), 32'h1);
        tick();
        check_eq("t4_g1", 32'(grant), 32'h2);
        req = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("t4_grant_rst", 32'(grant), 32'h0);
        check_eq("t4_done_rst", 32'(done), 32'h0);
        check_eq("t4_result_rst", result, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            check_eq($sformatf("t4_nodone_%0d", k), 32'(done), 32'h0);
        end
        req = 4'b0110;
        tick();
        check_eq("t4_post_grant", 32'(grant), 32'h2);
        req = '0;
        repeat (12) tick();

        // Idle stretch then one op; unit enable behaviour depends on build.
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq($sformatf("t5_idle_en_%0d", k), 32'(unit_clk_en), PS ? 32'h0 : 32'h1);
        end
        dataa[2*DATA_W +: DATA_W] = 32'd100;
        req = 4'b0100;
        tick();
        check_eq("t5_grant", 32'(grant), 32'h4);
        check_eq("t5_en_c1", 32'(unit_clk_en), 32'h1);
        req = '0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            check_eq($sformatf("t5_en_c%0d", c), 32'(unit_clk_en), (!PS || c <= 8) ? 32'h1 : 32'h0);
            check_eq($sformatf("t5_done_c%0d", c), 32'(done), (c == 9) ? 32'h4 : 32'h0);
            if (c == 9) check_eq("t5_result", result, 32'h42C8_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
